// File: rtl/goodness_threshold_ctrl.sv
// Per-sample goodness threshold decision: snapshot, per-core modulation commands, averager clear.
// Optional sticky overrun detection is built when GOODNESS_CTRL_OVERRUN_EN is defined.
module goodness_threshold_ctrl #(
  parameter int unsigned CORE_NUM       = 4,
  parameter int unsigned GOODNESS_WIDTH = 20,
  parameter int unsigned IDX_WIDTH      = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CORE_NUM*GOODNESS_WIDTH-1:0] avg_mem_bus,
  input  logic                               sample_end,
  input  logic                               label_pos,
  input  logic [GOODNESS_WIDTH-1:0]          threshold,
  output logic                               mod_valid,
  input  logic                               mod_ready,
  output logic [IDX_WIDTH-1:0]               mod_core_idx,
  output logic                               mod_dir,
  output logic [GOODNESS_WIDTH-1:0]          mod_err,
  output logic [CORE_NUM-1:0]                pass_mask,
  output logic [CORE_NUM-1:0]                core_clear_goodness,
  output logic                               busy,
  output logic                               done,
  output logic                               overrun
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CORE_NUM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_nxt;
  logic [IDX_WIDTH-1:0]      idx_q, idx_nxt;
  logic                      snap_en;
  logic                      label_q;
  logic [CORE_NUM-1:0]       pass_q;
  logic [CORE_NUM-1:0]       need_q;
  logic [GOODNESS_WIDTH-1:0] err_q [CORE_NUM];
  logic                      busy_q, done_q;
  logic [CORE_NUM-1:0]       clear_q;

  logic [CORE_NUM-1:0]       pass_c;
  logic [CORE_NUM-1:0]       need_c;
  logic [GOODNESS_WIDTH-1:0] err_c [CORE_NUM];

  // Per-lane compare and error magnitude; the subtraction order follows the compare result.
  for (genvar c = 0; c < CORE_NUM; c++) begin : g_lane
    logic [GOODNESS_WIDTH-1:0] lane_g;
    assign lane_g    = avg_mem_bus[c*GOODNESS_WIDTH +: GOODNESS_WIDTH];
    assign pass_c[c] = (lane_g >= threshold);
    assign err_c[c]  = pass_c[c] ? (lane_g - threshold) : (threshold - lane_g);
  end

  assign need_c = label_pos ? ~pass_c : pass_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    snap_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_end) begin
          snap_en   = 1'b1;
          idx_nxt   = '0;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!need_q[idx_q] || mod_ready) begin
          if (idx_q == LAST_IDX) state_nxt = ST_CLEAR;
          else                   idx_nxt   = idx_q + IDX_WIDTH'(1);
        end
      end
      ST_CLEAR: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot of label, pass mask and per-core command payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      label_q <= 1'b0;
      pass_q  <= '0;
      need_q  <= '0;
      for (int c = 0; c < CORE_NUM; c++) err_q[c] <= '0;
    end else if (snap_en) begin
      label_q <= label_pos;
      pass_q  <= pass_c;
      need_q  <= need_c;
      for (int c = 0; c < CORE_NUM; c++) err_q[c] <= err_c[c];
    end
  end

  // Status strobes registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clear_q <= '0;
    end else begin
      busy_q  <= (state_nxt != ST_IDLE);
      done_q  <= (state_nxt == ST_DONE);
      clear_q <= (state_nxt == ST_CLEAR) ? '1 : '0;
    end
  end

  assign mod_valid           = (state_q == ST_SCAN) && need_q[idx_q];
  assign mod_core_idx        = (state_q == ST_SCAN) ? idx_q : '0;
  assign mod_dir             = (state_q == ST_SCAN) && label_q;
  assign mod_err             = (state_q == ST_SCAN) ? err_q[idx_q] : '0;
  assign pass_mask           = pass_q;
  assign core_clear_goodness = clear_q;
  assign busy                = busy_q;
  assign done                = done_q;

`ifdef GOODNESS_CTRL_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  overrun_q <= 1'b0;
    else if (sample_end && state_q != ST_IDLE) overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule
